// File: rtl/cav_wave_cap.sv
// Waveform capture for the cavity model: boxcar-decimates field/forward/reflect I/Q,
// scales and saturates each sum, and stores records in a RAM with a registered read port.
module cav_wave_cap #(
  parameter int aw = 4,
  parameter int dw = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iq,
  input  logic signed [dw-1:0] field,
  input  logic signed [dw-1:0] forward,
  input  logic signed [dw-1:0] reflect,
  input  logic                 arm,
  input  logic                 trig,
  input  logic [7:0]           wave_decim,
  input  logic [2:0]           wave_shift,
  input  logic [aw+2:0]        rd_addr,
  output logic signed [dw-1:0] rd_data,
  output logic                 armed,
  output logic                 running,
  output logic                 done,
  output logic [aw:0]          rec_count
);
  localparam int AccW = dw + 8;
  localparam int Nrec = 1 << aw;

  typedef enum logic [2:0] {IDLE, ARMED, WAIT_I, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [7:0]             decim_q;
  logic [7:0]             pair_cnt;
  logic [2:0]             shift_q;
  logic signed [AccW-1:0] acc_i [3];
  logic signed [AccW-1:0] acc_q [3];
  logic signed [dw-1:0]   smp [3];
  logic signed [AccW-1:0] sum [3];
  logic                   proc, last, wr_en;
  logic [aw:0]            wr_addr;
  logic [3*dw-1:0]        wr_data;
  logic [3*dw-1:0]        mem [2**(aw+1)];
  logic [3*dw-1:0]        rd_word;

  function automatic logic signed [dw-1:0] scale_sat(input logic signed [AccW-1:0] acc,
                                                     input logic [2:0] sh);
    logic signed [AccW-1:0] s;
    s = acc >>> sh;
    if (s[AccW-1:dw-1] == {(AccW-dw+1){s[AccW-1]}})
      return signed'(s[dw-1:0]);
    else if (s[AccW-1])
      return signed'({1'b1, {(dw-1){1'b0}}});
    else
      return signed'({1'b0, {(dw-1){1'b1}}});
  endfunction

  // The first I sample after trig is taken in WAIT_I on the cycle that enters RUN.
  always_comb begin
    smp[0] = field;
    smp[1] = forward;
    smp[2] = reflect;
    for (int k = 0; k < 3; k++)
      sum[k] = (iq ? acc_i[k] : acc_q[k]) + AccW'(smp[k]);
    proc    = !arm && ((state == RUN) || (state == WAIT_I && iq));
    last    = (pair_cnt == decim_q);
    wr_en   = proc && last;
    wr_addr = {rec_count[aw-1:0], ~iq};
    wr_data = {scale_sat(sum[2], shift_q), scale_sat(sum[1], shift_q),
               scale_sat(sum[0], shift_q)};
  end

  always_comb begin
    state_nxt = state;
    if (arm)
      state_nxt = ARMED;
    else begin
      case (state)
        ARMED:   if (trig) state_nxt = WAIT_I;
        WAIT_I:  if (iq) state_nxt = RUN;
        RUN:     if (wr_en && !iq && rec_count == (aw+1)'(Nrec-1)) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  assign armed   = (state == ARMED);
  assign running = (state == WAIT_I) || (state == RUN);
  assign done    = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rec_count <= '0;
      pair_cnt  <= '0;
      for (int k = 0; k < 3; k++) begin
        acc_i[k] <= '0;
        acc_q[k] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (arm) begin
        rec_count <= '0;
        pair_cnt  <= '0;
        for (int k = 0; k < 3; k++) begin
          acc_i[k] <= '0;
          acc_q[k] <= '0;
        end
      end else if (proc) begin
        if (iq) begin
          for (int k = 0; k < 3; k++)
            acc_i[k] <= last ? '0 : sum[k];
        end else begin
          for (int k = 0; k < 3; k++)
            acc_q[k] <= last ? '0 : sum[k];
          pair_cnt <= last ? 8'd0 : pair_cnt + 8'd1;
          if (last)
            rec_count <= rec_count + (aw+1)'(1);
        end
      end
    end
  end

  // Capture settings are frozen at trig for the whole record set.
  always_ff @(posedge clk) begin
    if (state == ARMED && trig && !arm) begin
      decim_q <= wave_decim;
      shift_q <= wave_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  assign rd_word = mem[{rd_addr[aw+2:3], rd_addr[0]}];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_data <= '0;
    else begin
      case (rd_addr[2:1])
        2'd0:    rd_data <= signed'(rd_word[dw-1:0]);
        2'd1:    rd_data <= signed'(rd_word[2*dw-1:dw]);
        2'd2:    rd_data <= signed'(rd_word[3*dw-1:2*dw]);
        default: rd_data <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_cav_wave_cap.sv
// Directed bench for cav_wave_cap: capture, decimation/shift, saturation, ordering,
// re-arm and asynchronous reset behaviour.
module tb_cav_wave_cap;
  localparam int AW = 4;
  localparam int DW = 18;

  logic                 clk = 1'b0;
  logic                 rst_n, iq, arm, trig;
  logic signed [DW-1:0] field, forward, reflect;
  logic [7:0]           wave_decim;
  logic [2:0]           wave_shift;
  logic [AW+2:0]        rd_addr;
  logic signed [DW-1:0] rd_data;
  logic                 armed, running, done;
  logic [AW:0]          rec_count;

  int errors = 0;
  int checks = 0;
  int fi, fq, wi, wq, ri, rq;

  cav_wave_cap #(.aw(AW), .dw(DW)) dut (
    .clk(clk), .rst_n(rst_n), .iq(iq), .field(field), .forward(forward),
    .reflect(reflect), .arm(arm), .trig(trig), .wave_decim(wave_decim),
    .wave_shift(wave_shift), .rd_addr(rd_addr), .rd_data(rd_data),
    .armed(armed), .running(running), .done(done), .rec_count(rec_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply();
    field   = DW'(iq ? fi : fq);
    forward = DW'(iq ? wi : wq);
    reflect = DW'(iq ? ri : rq);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    iq = ~iq;
    apply();
  endtask

  task automatic set_smp(input int a, input int b, input int c, input int d,
                         input int e, input int f);
    fi = a; fq = b; wi = c; wq = d; ri = e; rq = f;
    apply();
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // trig lands on an iq=1 edge; the next edge is Q (WAIT_I), the one after enters RUN
  task automatic trig_i();
    if (!iq) tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic wait_done(input int exp, input string tag);
    int k = 0;
    while (!done && k < exp + 50) begin
      tick();
      k++;
    end
    chk(tag, k, exp);
  endtask

  task automatic wait_rec(input int n, input string tag);
    int k = 0;
    while (rec_count != (AW+1)'(n) && k < 500) begin
      tick();
      k++;
    end
    chk(tag, rec_count, n);
  endtask

  task automatic rd(input int rec, input int ch, input int q, input int exp,
                    input string tag);
    rd_addr = (AW+3)'(rec * 8 + ch * 2 + q);
    tick();
    chk($sformatf("%s r%0d c%0d q%0d", tag, rec, ch, q), rd_data, exp);
  endtask

  initial begin
    rst_n = 1'b0; iq = 1'b0; arm = 1'b0; trig = 1'b0;
    wave_decim = 8'd0; wave_shift = 3'd0; rd_addr = '0;
    set_smp(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("rst armed", armed, 0);
    chk("rst running", running, 0);
    chk("rst done", done, 0);
    chk("rst rec_count", rec_count, 0);
    chk("rst rd_data", rd_data, 0);
    rst_n = 1'b1;
    tick();

    // N=1, shift 0: one record per I/Q pair
    set_smp(1000, -500, 0, 0, 0, 0);
    pulse_arm();
    chk("t1 armed", armed, 1);
    trig_i();
    chk("t1 running", running, 1);
    wait_done(33, "t1 done latency");
    chk("t1 rec_count", rec_count, 16);
    for (int r = 0; r < 16; r++) begin
      rd(r, 0, 0, 1000, "t1 field");
      rd(r, 0, 1, -500, "t1 field");
      rd(r, 1, 0, 0, "t1 fwd");
      rd(r, 2, 1, 0, "t1 refl");
    end
    rd(3, 3, 0, 0, "t1 ch3");
    rd_addr = (AW+3)'(5 * 8);
    #1;
    chk("t1 latency before edge", rd_data, 0);
    tick();
    chk("t1 latency after edge", rd_data, 1000);

    // N=4, shift 2, settings changed after trig must be ignored
    set_smp(0, 0, 30000, 12, 0, 0);
    wave_decim = 8'd3; wave_shift = 3'd2;
    pulse_arm();
    trig_i();
    wave_decim = 8'd0; wave_shift = 3'd0;
    tick();
    chk("t2 rec_count at entry", rec_count, 0);
    for (int e = 1; e <= 128; e++) begin
      tick();
      chk($sformatf("t2 rec_count e%0d", e), rec_count, e / 8);
      if (e == 127) chk("t2 done e127", done, 0);
      if (e == 128) chk("t2 done e128", done, 1);
    end
    for (int r = 0; r < 16; r++) begin
      rd(r, 1, 0, 30000, "t2 fwd");
      rd(r, 1, 1, 12, "t2 fwd");
    end
    rd(0, 0, 0, 0, "t2 field");

    // saturation: N=256, shift 0
    set_smp(131071, 0, 300, -3, 0, -131072);
    wave_decim = 8'd255; wave_shift = 3'd0;
    pulse_arm();
    trig_i();
    wait_done(1 + 8192, "t3 done latency");
    for (int r = 0; r < 16; r += 15) begin
      rd(r, 0, 0, 131071, "t3 field");
      rd(r, 0, 1, 0, "t3 field");
      rd(r, 2, 0, 0, "t3 refl");
      rd(r, 2, 1, -131072, "t3 refl");
      rd(r, 1, 0, 76800, "t3 fwd");
      rd(r, 1, 1, -768, "t3 fwd");
    end

    // N=128, shift 7: full-scale sums land exactly in range
    wave_decim = 8'd127; wave_shift = 3'd7;
    pulse_arm();
    trig_i();
    wait_done(1 + 4096, "t3b done latency");
    rd(0, 0, 0, 131071, "t3b field");
    rd(0, 2, 1, -131072, "t3b refl");
    rd(9, 1, 0, 300, "t3b fwd");
    rd(9, 1, 1, -3, "t3b fwd");

    // trig without arm is ignored
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_smp(7, 7, 7, 7, 7, 7);
    wave_decim = 8'd0; wave_shift = 3'd0;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    repeat (4) tick();
    chk("t4 lone trig armed", armed, 0);
    chk("t4 lone trig running", running, 0);
    chk("t4 lone trig done", done, 0);
    rd(0, 0, 0, 131071, "t4 no write");

    // arm and trig together: arm wins
    arm = 1'b1; trig = 1'b1;
    tick();
    arm = 1'b0; trig = 1'b0;
    chk("t4 arm+trig armed", armed, 1);
    chk("t4 arm+trig running", running, 0);
    tick();
    chk("t4 arm+trig still armed", armed, 1);

    // trig on an I cycle: RUN starts two edges later
    set_smp(11, -22, 0, 0, 0, 0);
    trig_i();
    chk("t4 trig running", running, 1);
    chk("t4 T rec", rec_count, 0);
    tick();
    chk("t4 T+1 rec", rec_count, 0);
    tick();
    chk("t4 T+2 rec", rec_count, 0);
    tick();
    chk("t4 T+3 rec", rec_count, 1);

    // re-arm mid capture
    wait_rec(7, "t5 reach rec7");
    pulse_arm();
    chk("t5 rearm rec_count", rec_count, 0);
    chk("t5 rearm running", running, 0);
    chk("t5 rearm armed", armed, 1);
    chk("t5 rearm done", done, 0);
    set_smp(33, -44, 0, 0, 0, 0);
    trig_i();
    wait_done(33, "t5 done latency");
    rd(0, 0, 0, 33, "t5 field");
    rd(0, 0, 1, -44, "t5 field");
    rd(15, 0, 0, 33, "t5 field");

    // asynchronous reset at record 5
    set_smp(55, -66, 0, 0, 0, 0);
    rd_addr = (AW+3)'(15 * 8);
    pulse_arm();
    trig_i();
    wait_rec(5, "t6 reach rec5");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 async armed", armed, 0);
    chk("t6 async running", running, 0);
    chk("t6 async done", done, 0);
    chk("t6 async rec_count", rec_count, 0);
    chk("t6 async rd_data", rd_data, 0);
    #10;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t6 post done", done, 0);
    chk("t6 post running", running, 0);
    rd(0, 0, 0, 55, "t6 kept");
    rd(4, 0, 0, 55, "t6 kept");
    rd(4, 0, 1, -66, "t6 kept");
    rd(5, 0, 0, 33, "t6 untouched");
    rd(5, 0, 1, -44, "t6 untouched");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cav_wave_cap.md
Name: cav_wave_cap

Overview:
- Downstream capture stage for the cavity electrical model. Consumes the interleaved I/Q `field`, `forward` and `reflect` streams.
- Boxcar-decimates each of the six components (3 channels × I/Q), scales and saturates the sums, and stores them in an internal waveform buffer.
- Capture is armed and triggered. The buffer is read back through a synchronous single-clock read port, for bench checks and local-bus exposure by the parent.

Parameters:
- aw, 4, log2 of record depth (2^aw records; one record = 6 stored components)
- dw, 18, input/stored sample width (signed)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- iq  input  1  1 = current samples are I, 0 = Q; alternates every cycle
- field  input  dw  signed cavity probe sample
- forward  input  dw  signed forward sample
- reflect  input  dw  signed reflected sample
- arm  input  1  single-cycle pulse; arms capture
- trig  input  1  single-cycle pulse; starts an armed capture
- wave_decim  input  8  pairs per record minus 1 (N = wave_decim+1, 1..256)
- wave_shift  input  3  arithmetic right shift applied to sums
- rd_addr  input  aw+3  {record, ch[1:0], iq_sel}; ch 0=field, 1=forward, 2=reflect, 3=unused; iq_sel 0=I, 1=Q
- rd_data  output  dw  registered read data
- armed  output  1  waiting for trig
- running  output  1  capture in progress
- done  output  1  buffer complete, holds until next arm
- rec_count  output  aw+1  records written in current capture

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE. `armed`, `running`, `done`, `rec_count`, `rd_data`, all accumulators and the pair counter go to 0.
  - Buffer RAM is not cleared.
- FSM states: IDLE, ARMED, WAIT_I, RUN, DONE.
  - IDLE/DONE/RUN/WAIT_I --arm--> ARMED. This clears `rec_count`, accumulators and the pair counter, and clears `done`.
  - ARMED --trig--> WAIT_I. `wave_decim` and `wave_shift` are latched on the trig cycle and held for the whole capture.
  - `trig` outside ARMED is ignored. When `arm` and `trig` coincide, `arm` wins and `trig` is ignored.
  - WAIT_I --first cycle with iq=1 strictly after the trig cycle--> RUN; that cycle is accumulated as the first I sample.
  - RUN --write of Q word of record 2^aw-1--> DONE.
- `armed` = (state==ARMED). `running` = (state==WAIT_I or RUN). `done` = (state==DONE).
- Accumulation:
  - Six signed accumulators, dw+8 = 26 bits wide; no overflow is possible for N≤256.
  - On iq=1 cycles, add each channel sample to its I accumulator; on iq=0 cycles, add to its Q accumulator.
  - The pair counter counts completed Q cycles modulo N.
- Record write:
  - On the I cycle of the Nth pair, each of the three I results (acc + sample) >>> wave_shift is saturated to [-2^(dw-1), 2^(dw-1)-1]. The three results are written in one 3·dw-bit RAM word at {record,0}, and the I accumulators are cleared to 0 in the same cycle.
  - The next (Q) cycle does the same for the Q components at {record,1}, clears the Q accumulators, and increments `rec_count`.
  - N=1 must work: every cycle is a write.
- Fixed capture length: 2·N·2^aw cycles from RUN entry to DONE.
- Read port:
  - `rd_data` is registered, with 1-cycle latency from `rd_addr`. It selects word {record,iq_sel} and slice ch.
  - ch=3 returns 0.
  - Reads are allowed in any state. A same-cycle read of the word being written returns the old contents.
- Input `iq` not alternating is a caller error. The block follows `iq` literally, with no resync.
- Reset mid-capture aborts immediately. No further RAM writes occur until the next arm+trig.

Test Plan:
- aw=4, wave_decim=0, wave_shift=0, field I=1000 Q=-500, others 0; arm, trig → `done` after 32 cycles. Field reads: I=1000, Q=-500 in all 16 records. Forward and reflect read 0. ch=3 reads 0. Read latency is 1 cycle.
- wave_decim=3 (N=4), wave_shift=2, forward I=30000 Q=12; arm, trig → every forward I=30000, Q=12. `rec_count` steps 0→16, incrementing every 8 cycles. `done` asserts 128 cycles after RUN entry.
- Saturation: wave_decim=255, wave_shift=0, field I=131071, reflect Q=-131072 → stored field I=131071 and reflect Q=-131072, both clipped. With wave_shift=7 and field I=131071 → stored 131071, not clipped.
- Ordering:
  - trig with no prior arm → stays IDLE and no RAM writes.
  - arm and trig on the same cycle → ARMED only.
  - arm, then trig on an iq=1 cycle → RUN starts at the next iq=1 cycle, 2 cycles later.
- arm pulse at record 7 of a capture → `rec_count` goes to 0, `running` goes to 0, and `armed` goes to 1. A subsequent trig overwrites from record 0.
- rst_n low at record 5 → all outputs 0 asynchronously. After release, `done` stays 0 and records 0–4 retain their previous data.
